// File: rtl/bombe_sweep_controller_if.sv
// Bus between the bombe sweep sequencer and its environment: character capture,
// sweep control, the datapath match flag and the registered status outputs.
interface bombe_sweep_controller_if;
  logic       clear;
  logic [7:0] char_in;
  logic       char_valid;
  logic       go;
  logic       step_en;
  logic       match;
  logic [7:0] char_out;
  logic       load_s0;
  logic       load_s1;
  logic       load_s2;
  logic [4:0] rotor_out;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] result;
  logic [3:0] state_out;

  modport master (
    output clear, char_in, char_valid, go, step_en, match,
    input  char_out, load_s0, load_s1, load_s2, rotor_out,
           busy, done, found, result, state_out
  );

  modport slave (
    input  clear, char_in, char_valid, go, step_en, match,
    output char_out, load_s0, load_s1, load_s2, rotor_out,
           busy, done, found, result, state_out
  );
endinterface

// File: rtl/bombe_sweep_controller.sv
// Bombe sweep sequencer: captures three ciphertext characters, then steps the rotor
// offset 0..ROTOR_MAX on a single clock with a step enable, reporting the first match.
module bombe_sweep_controller #(
  parameter logic [4:0] ROTOR_MAX = 5'd25,
  parameter logic [7:0] ERROR_VAL = 8'hFF,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  bombe_sweep_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_LOAD0  = 4'd0,
    S_LOAD1  = 4'd1,
    S_LOAD2  = 4'd2,
    S_ARMED  = 4'd3,
    S_SETTLE = 4'd4,
    S_SAMPLE = 4'd5,
    S_DONE   = 4'd6
  } state_e;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_e     state_q;
  logic [7:0] char_q;
  logic [2:0] load_q;
  logic [4:0] rotor_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       found_q;
  logic [7:0] result_q;

  logic [4:0] rotor_d;
  state_e     step_state_d;

  assign rotor_d = rotor_q + 5'd1;
  // With no settle time the rotor change is immediately eligible for sampling.
  assign step_state_d = (SETTLE_CNT == 4'd0) ? S_SAMPLE : S_SETTLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD0;
      char_q   <= 8'd0;
      load_q   <= 3'b000;
      rotor_q  <= 5'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      result_q <= 8'd0;
    end else if (bus.clear) begin
      // Soft restart keeps the last captured character on char_out.
      state_q  <= S_LOAD0;
      load_q   <= 3'b000;
      rotor_q  <= 5'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      result_q <= 8'd0;
    end else begin
      load_q <= 3'b000;
      case (state_q)
        S_LOAD0: begin
          if (bus.char_valid) begin
            char_q  <= bus.char_in;
            load_q  <= 3'b001;
            state_q <= S_LOAD1;
          end
        end
        S_LOAD1: begin
          if (bus.char_valid) begin
            char_q  <= bus.char_in;
            load_q  <= 3'b010;
            state_q <= S_LOAD2;
          end
        end
        S_LOAD2: begin
          if (bus.char_valid) begin
            char_q  <= bus.char_in;
            load_q  <= 3'b100;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (bus.go) begin
            rotor_q <= 5'd0;
            busy_q  <= 1'b1;
            cnt_q   <= SETTLE_CNT;
            state_q <= step_state_d;
          end
        end
        S_SETTLE: begin
          if (cnt_q <= 4'd1) begin
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          // A match at the last offset still counts as found.
          if (bus.step_en) begin
            if (bus.match) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              found_q  <= 1'b1;
              result_q <= {3'b000, rotor_q};
            end else if (rotor_q == ROTOR_MAX) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              found_q  <= 1'b0;
              result_q <= ERROR_VAL;
            end else begin
              rotor_q <= rotor_d;
              cnt_q   <= SETTLE_CNT;
              state_q <= step_state_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_LOAD0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.char_out  = char_q;
  assign bus.load_s0   = load_q[0];
  assign bus.load_s1   = load_q[1];
  assign bus.load_s2   = load_q[2];
  assign bus.rotor_out = rotor_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.result    = result_q;
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_bombe_sweep_controller.sv
// Scoreboard bench for bombe_sweep_controller with a behavioural shift-subtract
// datapath model supplying match from the captured characters.
module tb_bombe_sweep_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bombe_sweep_controller_if bus0();
  bombe_sweep_controller_if bus1();

  bombe_sweep_controller #(.SETTLE(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  bombe_sweep_controller #(.SETTLE(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Datapath model: three ascii registers and the crib compare against "ABC".
  logic [7:0] s0 = 8'd0, s1 = 8'd0, s2 = 8'd0;
  logic [7:0] t0 = 8'd0, t1 = 8'd0, t2 = 8'd0;

  always @(posedge clk) begin
    if (bus0.load_s0) s0 <= bus0.char_out;
    if (bus0.load_s1) s1 <= bus0.char_out;
    if (bus0.load_s2) s2 <= bus0.char_out;
    if (bus1.load_s0) t0 <= bus1.char_out;
    if (bus1.load_s1) t1 <= bus1.char_out;
    if (bus1.load_s2) t2 <= bus1.char_out;
  end

  function automatic int md(input int x);
    return ((x % 26) + 26) % 26;
  endfunction

  function automatic logic match_f(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] c, input logic [4:0] r);
    int ri;
    ri = int'(r);
    return (md(int'(a) - 65 - ri) == 0) && (md(int'(b) - 65 - ri - 1) == 1) &&
           (md(int'(c) - 65 - ri - 2) == 2);
  endfunction

  assign bus0.match = match_f(s0, s1, s2, bus0.rotor_out);
  assign bus1.match = match_f(t0, t1, t2, bus1.rotor_out);

  typedef struct { int idx; int ch; int cyc; } load_t;
  typedef struct { int found; int res; int rot; int cyc; } done_t;
  load_t load_q[$];
  done_t done_q[$];

  // Monitor: pops an expectation whenever dut0 presents a load pulse or a done edge.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    int    nl;
    load_t le;
    done_t de;
    nl = int'(bus0.load_s0) + int'(bus0.load_s1) + int'(bus0.load_s2);
    if (nl != 0) begin
      if (load_q.size() == 0) begin
        chk("unexpected_load", nl, 0);
      end else begin
        le = load_q.pop_front();
        chk("load_onehot", nl, 1);
        chk("load_idx", bus0.load_s0 ? 0 : (bus0.load_s1 ? 1 : 2), le.idx);
        chk("load_char", int'(bus0.char_out), le.ch);
        chk("load_cycle", cyc, le.cyc);
      end
    end
    if (bus0.done && !prev_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        de = done_q.pop_front();
        chk("done_found", int'(bus0.found), de.found);
        chk("done_result", int'(bus0.result), de.res);
        chk("done_rotor", int'(bus0.rotor_out), de.rot);
        chk("done_busy_low", int'(bus0.busy), 0);
        if (de.cyc >= 0) chk("done_latency", cyc, de.cyc);
      end
    end
    prev_done = bus0.done;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c, input int k, input bit exp_load);
    load_t le;
    bus0.char_in    = c;
    bus0.char_valid = 1'b1;
    if (exp_load) begin
      le.idx = k; le.ch = int'(c); le.cyc = cyc + 1;
      load_q.push_back(le);
    end
    @(negedge clk);
    bus0.char_valid = 1'b0;
  endtask

  task automatic load3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_char(a, 0, 1'b1);
    idle(2);
    send_char(b, 1, 1'b1);
    idle(2);
    send_char(c, 2, 1'b1);
  endtask

  task automatic do_go(input bit push, input int f, input int r, input int rot, input int lat);
    done_t de;
    bus0.go = 1'b1;
    if (push) begin
      de.found = f; de.res = r; de.rot = rot;
      de.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
      done_q.push_back(de);
    end
    @(negedge clk);
    bus0.go = 1'b0;
  endtask

  task automatic pulse_clear();
    bus0.clear = 1'b1;
    @(negedge clk);
    bus0.clear = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus0.done; i++) @(negedge clk);
    chk("done_reached", int'(bus0.done), 1);
  endtask

  task automatic wait_rotor10(input int budget);
    for (int i = 0; i < budget && !(bus0.state_out == 4'd5 && bus0.rotor_out == 5'd10); i++)
      @(negedge clk);
    chk("reached_sample_r10", int'(bus0.state_out == 4'd5 && bus0.rotor_out == 5'd10), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int g;
    logic [4:0] r0;
    bus0.clear = 1'b0; bus0.char_in = 8'd0; bus0.char_valid = 1'b0; bus0.go = 1'b0; bus0.step_en = 1'b1;
    bus1.clear = 1'b0; bus1.char_in = 8'd0; bus1.char_valid = 1'b0; bus1.go = 1'b0; bus1.step_en = 1'b1;
    reset = 1'b1;
    idle(3);
    chk("rst_state", int'(bus0.state_out), 0);
    chk("rst_char_out", int'(bus0.char_out), 0);
    chk("rst_loads", int'({bus0.load_s0, bus0.load_s1, bus0.load_s2}), 0);
    chk("rst_rotor", int'(bus0.rotor_out), 0);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_done", int'(bus0.done), 0);
    chk("rst_found", int'(bus0.found), 0);
    chk("rst_result", int'(bus0.result), 0);
    chk("rst_state_s0build", int'(bus1.state_out), 0);
    reset = 1'b0;
    idle(1);

    // D,F,H with go abused during LOAD1; match at r=3.
    send_char("D", 0, 1'b1);
    idle(1);
    do_go(1'b0, 0, 0, 0, -1);
    chk("go_in_load1_state", int'(bus0.state_out), 1);
    chk("go_in_load1_busy", int'(bus0.busy), 0);
    send_char("F", 1, 1'b1);
    idle(2);
    send_char("H", 2, 1'b1);
    chk("armed_state", int'(bus0.state_out), 3);
    idle(1);
    do_go(1'b1, 1, 8'h03, 3, 8);
    wait_done(40);
    send_char("X", 0, 1'b0);
    do_go(1'b0, 0, 0, 0, -1);
    idle(2);
    chk("done_char_held", int'(bus0.char_out), int'(8'h48));
    chk("done_state_held", int'(bus0.state_out), 6);
    chk("done_result_held", int'(bus0.result), 3);

    // Clear, then an exhaustive miss: rotor must stop at ROTOR_MAX.
    pulse_clear();
    chk("clr_state", int'(bus0.state_out), 0);
    chk("clr_done", int'(bus0.done), 0);
    chk("clr_found", int'(bus0.found), 0);
    chk("clr_result", int'(bus0.result), 0);
    chk("clr_char_kept", int'(bus0.char_out), int'(8'h48));
    load3("A", "A", "A");
    idle(1);
    do_go(1'b1, 0, 8'hFF, 25, 52);
    wait_done(80);
    idle(3);
    chk("nowrap_rotor", int'(bus0.rotor_out), 25);
    chk("nowrap_state", int'(bus0.state_out), 6);

    // Match exactly at the last offset.
    pulse_clear();
    load3("Z", "B", "D");
    idle(1);
    do_go(1'b1, 1, 8'h19, 25, 52);
    wait_done(80);

    // step_en pulsed every 4th clock.
    pulse_clear();
    load3("D", "F", "H");
    bus0.step_en = 1'b0;
    idle(1);
    do_go(1'b1, 1, 8'h03, 3, -1);
    ok = 1'b1;
    for (int i = 0; i < 200 && !bus0.done; i++) begin
      bus0.step_en = (i % 4 == 3);
      r0 = bus0.rotor_out;
      @(negedge clk);
      if (!bus0.step_en && bus0.rotor_out != r0) ok = 1'b0;
      if (!bus0.done && !bus0.busy) ok = 1'b0;
    end
    chk("step_gated_busy", int'(ok), 1);
    chk("step_done", int'(bus0.done), 1);
    bus0.step_en = 1'b1;

    // clear mid-sweep at r=10, then a fresh sweep.
    pulse_clear();
    load3("A", "A", "A");
    idle(1);
    do_go(1'b0, 0, 0, 0, -1);
    wait_rotor10(60);
    pulse_clear();
    chk("midclr_state", int'(bus0.state_out), 0);
    chk("midclr_busy", int'(bus0.busy), 0);
    chk("midclr_rotor", int'(bus0.rotor_out), 0);
    load3("D", "F", "H");
    idle(1);
    do_go(1'b1, 1, 8'h03, 3, 8);
    wait_done(40);

    // reset mid-sweep also zeroes char_out.
    pulse_clear();
    load3("A", "A", "A");
    idle(1);
    do_go(1'b0, 0, 0, 0, -1);
    wait_rotor10(60);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_char_out", int'(bus0.char_out), 0);
    chk("midrst_state", int'(bus0.state_out), 0);
    chk("midrst_busy", int'(bus0.busy), 0);
    chk("midrst_rotor", int'(bus0.rotor_out), 0);
    load3("D", "F", "H");
    idle(1);
    do_go(1'b1, 1, 8'h03, 3, 8);
    wait_done(40);

    // clear and char_valid together in LOAD0: the char is dropped.
    pulse_clear();
    bus0.clear = 1'b1; bus0.char_in = "Q"; bus0.char_valid = 1'b1;
    @(negedge clk);
    bus0.clear = 1'b0; bus0.char_valid = 1'b0;
    idle(2);
    chk("clrcv_state", int'(bus0.state_out), 0);
    chk("clrcv_char_kept", int'(bus0.char_out), int'(8'h48));

    // Zero-settle build: D,F,H completes 4 clocks after go.
    bus1.char_in = "D"; bus1.char_valid = 1'b1; @(negedge clk);
    bus1.char_in = "F"; @(negedge clk);
    bus1.char_in = "H"; @(negedge clk);
    bus1.char_valid = 1'b0;
    idle(1);
    chk("s0build_armed", int'(bus1.state_out), 3);
    bus1.go = 1'b1;
    g = cyc + 1;
    @(negedge clk);
    bus1.go = 1'b0;
    for (int i = 0; i < 20 && !bus1.done; i++) @(negedge clk);
    chk("s0build_done", int'(bus1.done), 1);
    chk("s0build_latency", cyc - g, 4);
    chk("s0build_found", int'(bus1.found), 1);
    chk("s0build_result", int'(bus1.result), 3);

    idle(3);
    chk("load_queue_drained", load_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bombe_sweep_controller.md
Name: bombe_sweep_controller

Overview:
- Sequencer for the bombe deduction datapath (three ciphertext registers, shift-subtract stage, crib compare against "ABC").
- Captures three ciphertext characters through a strobe handshake and pulses the matching register load.
- On go, sweeps rotor offsets 0..ROTOR_MAX, sampling the datapath match flag once per step, and reports the first matching offset or the error value.
- Replaces the gated-clock rotor stepping with a single-clock step enable.

Parameters:
- ROTOR_MAX, 25, last offset swept; 5-bit.
- ERROR_VAL, 8'hFF, result value when no offset matches.
- SETTLE, 1, clk cycles waited after every rotor_out change before match is eligible to be sampled; 0..15.

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft restart to LOAD0
- char_in  in  8  ASCII ciphertext character
- char_valid  in  1  one-cycle strobe, char_in valid
- go  in  1  start sweep, accepted only in ARMED
- step_en  in  1  advance qualifier (tick or tied high)
- match  in  1  datapath: all three decrypted chars equal crib at rotor_out
- char_out  out  8  registered captured character, feeds all three ascii registers
- load_s0 / load_s1 / load_s2  out  1 each  one-cycle load pulses
- rotor_out  out  5  current offset
- busy  out  1  high in SETTLE/SAMPLE
- done  out  1  high in DONE
- found  out  1  valid when done; 1 = match
- result  out  8  {3'b0,offset} or ERROR_VAL; valid when done
- state_out  out  4  encoded state, debug

Behaviour:
- All outputs are registered. Reset values: state LOAD0, char_out 0, load_s* 0, rotor_out 0, busy 0, done 0, found 0, result 0.
- Priority: reset > clear > all other inputs.
- State encoding: LOAD0=0, LOAD1=1, LOAD2=2, ARMED=3, SETTLE=4, SAMPLE=5, DONE=6. Unused codes go to LOAD0 on the next clk.
- LOADk (k=0..2), on char_valid:
  - char_out <= char_in.
  - load_sk = 1 in the following cycle, exactly one cycle wide.
  - Advance to LOAD(k+1); LOAD2 advances to ARMED.
  - Load latency is 1 cycle; char_out holds until the next accepted char.
- char_valid is ignored outside LOAD states. go is ignored outside ARMED.
- ARMED, on go: rotor_out <= 0, busy <= 1, go to SETTLE with the counter loaded to SETTLE. If SETTLE=0, go straight to SAMPLE.
- SETTLE: the counter decrements each clk. After exactly SETTLE cycles in this state, go to SAMPLE. match is not looked at in SETTLE.
- SAMPLE: wait for step_en. On step_en:
  - match=1: go to DONE, found=1, result={3'b0,rotor_out}. A match wins over end of range, including at rotor_out==ROTOR_MAX.
  - else if rotor_out==ROTOR_MAX: go to DONE, found=0, result=ERROR_VAL, rotor_out stays at ROTOR_MAX.
  - else: rotor_out <= rotor_out+1 and go to SETTLE. There is no wrap past ROTOR_MAX.
- SAMPLE is left only on step_en. Each offset costs SETTLE+1 cycles with step_en tied high.
- DONE: done=1, busy=0. found, result and rotor_out are held until clear or reset. go is ignored in DONE.
- clear in any state, applied the next cycle:
  - state goes to LOAD0.
  - rotor_out, busy, done, found and result go to 0.
  - A pending load pulse is cancelled.
  - char_out is retained.
- clear and char_valid in the same cycle: clear wins and the char is dropped.
- reset mid-sweep behaves as clear and also zeroes char_out.

Test Plan:
- Datapath model for all scenarios: match iff (s0-r, s1-(r+1), s2-(r+2)) mod 26 == (A,B,C). SETTLE=1 unless stated.
- Load "D","F","H" with strobes 3 cycles apart, step_en=1, go -> load_s0/1/2 each pulse 1 cycle after their strobe. done rises 8 clk after go is sampled, found=1, result=8'h03, rotor_out=3.
- Load "A","A","A", go, step_en=1 -> no match. done after 52 clk, found=0, result=8'hFF, rotor_out=25 (must not wrap to 0).
- Load "Z","B","D", go -> match at the boundary r=25. found=1, result=8'h19, not ERROR_VAL.
- "D","F","H" with step_en pulsed every 4th clk -> rotor_out advances only after pulses. done with result=8'h03. busy high throughout the sweep; no advance without step_en.
- clear asserted while rotor_out=10 in SAMPLE -> next cycle state_out=0, busy=0, rotor_out=0. Reload "D","F","H" and go -> result=8'h03. Repeat using reset: same result, and char_out=0 immediately after reset.
- Protocol abuse:
  - go during LOAD1 is ignored.
  - char_valid during SAMPLE/DONE does not change char_out and produces no load pulse.
  - clear+char_valid in the same cycle in LOAD0 gives no load_s0 pulse.
  - SETTLE=0 build: "D","F","H" gives done 4 clk after go.
